// File: rtl/motor_command_arbiter.sv
// -----------------------------------------------------------------------------
// motor_command_arbiter
//
// Sits between the line-sensor direction decoder and the two H-bridge drivers.
// Picks either the autonomous line-follow command or a manual override, turns
// the selected command into per-wheel duty targets, sequences timed 90-degree
// pivot turns with a dead-time window on either side of the wheel reversal,
// and produces per-wheel PWM and direction outputs.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   line_dir   line-follow command {dir[1:0], intensity[1:0]}
//              dir: 00 proceed, 01 left, 10 right, 11 stop
//              intensity: 00 full, 01 veer, 10 hard, 11 90-degree
//   line_valid line_dir qualifier (strobe or level)
//   man_req    manual override request (level)
//   man_dir    manual command, same encoding as line_dir
//   man_grant  manual source currently owns the motors (registered)
//   pwm_l/r    per-wheel PWM (registered)
//   fwd_l/r    per-wheel direction, 1 = forward (registered)
//   busy       high while in a dead-time or turn state (registered)
//
// Optional feature (compile-time macro MOTOR_WATCHDOG_EN):
//   when defined, a line command that is not refreshed by line_valid within
//   WATCHDOG_CYCLES is replaced by stop while the manual source is not granted.
//   When undefined, the last valid line command persists indefinitely.
// -----------------------------------------------------------------------------
module motor_command_arbiter #(
  parameter int unsigned PWM_PERIOD      = 1000,
  parameter int unsigned DUTY_FULL       = 1000,
  parameter int unsigned DUTY_VEER       = 600,
  parameter int unsigned DUTY_HARD       = 300,
  parameter int unsigned TURN_CYCLES     = 25_000_000,
  parameter int unsigned DEAD_CYCLES     = 50_000,
  parameter int unsigned WATCHDOG_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] line_dir,
  input  logic       line_valid,
  input  logic       man_req,
  input  logic [3:0] man_dir,
  output logic       man_grant,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       fwd_l,
  output logic       fwd_r,
  output logic       busy
);

  // PWM counter and duty registers share one width so they compare directly.
  localparam int unsigned PwmMax = (PWM_PERIOD > DUTY_FULL) ? PWM_PERIOD : DUTY_FULL;
  localparam int unsigned PwmW   = $clog2(PwmMax + 1);
  localparam int unsigned TmrMax = (TURN_CYCLES > DEAD_CYCLES) ? TURN_CYCLES : DEAD_CYCLES;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);

  localparam logic [PwmW-1:0] CntLast  = PwmW'(PWM_PERIOD - 1);
  localparam logic [PwmW-1:0] DutyFull = PwmW'(DUTY_FULL);
  localparam logic [PwmW-1:0] DutyVeer = PwmW'(DUTY_VEER);
  localparam logic [PwmW-1:0] DutyHard = PwmW'(DUTY_HARD);
  localparam logic [TmrW-1:0] DeadLast = TmrW'(DEAD_CYCLES - 1);
  localparam logic [TmrW-1:0] TurnLast = TmrW'(TURN_CYCLES - 1);

  localparam logic [3:0] CmdStop = 4'b1111;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StDeadIn,
    StTurn,
    StDeadOut
  } state_e;

  state_e          state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            turn_left_q, turn_left_d;
  logic [3:0]      line_cmd_q, line_cmd_d;
  logic            man_grant_q, man_grant_d;
  logic [PwmW-1:0] cnt_q, cnt_d;
  logic [PwmW-1:0] tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
  logic [PwmW-1:0] duty_l_q, duty_l_d, duty_r_q, duty_r_d;
  logic            pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;
  logic            fwd_l_q, fwd_l_d, fwd_r_q, fwd_r_d;
  logic            busy_q, busy_d;

  logic [3:0]      line_eff;
  logic [3:0]      sel_cmd;
  logic            sel_turn;
  logic            sel_stop;
  logic            wd_fire;
  logic            pivot;

  // ---------------------------------------------------------------------------
  // Line command watchdog
  // ---------------------------------------------------------------------------
`ifdef MOTOR_WATCHDOG_EN
  localparam int unsigned     WdW     = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WdW-1:0]  WdLimit = WdW'(WATCHDOG_CYCLES);

  logic [WdW-1:0] wd_q, wd_d;

  // Saturates at the limit so the forced stop holds until the next line_valid.
  always_comb begin
    wd_d = wd_q;
    if (line_valid) begin
      wd_d = '0;
    end else if (wd_q != WdLimit) begin
      wd_d = wd_q + 1'b1;
    end
  end

  assign wd_fire = (wd_q == WdLimit) && !man_grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_wd_cycles;
  assign unused_wd_cycles = ^WATCHDOG_CYCLES;
  assign wd_fire          = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Command selection
  // ---------------------------------------------------------------------------
  // A fresh line_valid is used in the same cycle so the target duty follows a
  // command change one cycle later; otherwise the latched command applies.
  always_comb begin
    line_eff = line_cmd_q;
    if (line_valid) begin
      line_eff = line_dir;
    end else if (wd_fire) begin
      line_eff = CmdStop;
    end
  end

  assign line_cmd_d = line_eff;
  assign sel_cmd    = man_req ? man_dir : line_eff;
  assign sel_turn   = ((sel_cmd[3:2] == 2'b01) || (sel_cmd[3:2] == 2'b10)) &&
                      (sel_cmd[1:0] == 2'b11);
  assign sel_stop   = (sel_cmd[3:2] == 2'b11);

  // Target duties from the selected command. A 90-degree command maps to the
  // pivot duties, which only matter once the turn sequence owns the wheels.
  always_comb begin
    tgt_l_d = DutyFull;
    tgt_r_d = DutyFull;
    unique case (sel_cmd[3:2])
      2'b00: begin
        tgt_l_d = DutyFull;
        tgt_r_d = DutyFull;
      end
      2'b01: begin
        if (sel_cmd[1:0] == 2'b10) begin
          tgt_l_d = DutyHard;
        end else if (sel_cmd[1:0] != 2'b11) begin
          tgt_l_d = DutyVeer;
        end
      end
      2'b10: begin
        if (sel_cmd[1:0] == 2'b10) begin
          tgt_r_d = DutyHard;
        end else if (sel_cmd[1:0] != 2'b11) begin
          tgt_r_d = DutyVeer;
        end
      end
      default: begin
        tgt_l_d = '0;
        tgt_r_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Turn sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    turn_left_d = turn_left_q;
    man_grant_d = man_grant_q;
    unique case (state_q)
      StIdle, StDrive: begin
        // Arbitration is only live here; the grant is frozen during a turn.
        man_grant_d = man_req;
        if (sel_turn) begin
          state_d     = StDeadIn;
          tmr_d       = '0;
          turn_left_d = (sel_cmd[3:2] == 2'b01);
        end else if (sel_stop) begin
          state_d = StIdle;
        end else begin
          state_d = StDrive;
        end
      end
      StDeadIn: begin
        if (tmr_q == DeadLast) begin
          state_d = StTurn;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StTurn: begin
        if (tmr_q == TurnLast) begin
          state_d = StDeadOut;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StDeadOut: begin
        if (tmr_q == DeadLast) begin
          state_d = StDrive;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        tmr_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, computed from next-state values so they line up with
  // the state they describe rather than lagging it by a cycle.
  // ---------------------------------------------------------------------------
  assign busy_d = (state_d == StDeadIn) || (state_d == StTurn) || (state_d == StDeadOut);

  // Reversed direction is presented on the last dead-in cycle and through TURN.
  assign pivot   = (state_d == StTurn) || ((state_d == StDeadIn) && (tmr_d == DeadLast));
  assign fwd_l_d = !(pivot && turn_left_d);
  assign fwd_r_d = !(pivot && !turn_left_d);

  assign cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;

  // Applied duty changes only at the period wrap, except that dead-time forces
  // zero at once and the pivot duty is applied for the whole timed TURN window.
  always_comb begin
    duty_l_d = duty_l_q;
    duty_r_d = duty_r_q;
    if ((state_d == StDeadIn) || (state_d == StDeadOut)) begin
      duty_l_d = '0;
      duty_r_d = '0;
    end else if (state_d == StTurn) begin
      duty_l_d = DutyFull;
      duty_r_d = DutyFull;
    end else if (cnt_q == CntLast) begin
      duty_l_d = tgt_l_q;
      duty_r_d = tgt_r_q;
    end
  end

  assign pwm_l_d = (cnt_d < duty_l_d);
  assign pwm_r_d = (cnt_d < duty_r_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tmr_q       <= '0;
      turn_left_q <= 1'b0;
      line_cmd_q  <= CmdStop;
      man_grant_q <= 1'b0;
      cnt_q       <= '0;
      tgt_l_q     <= '0;
      tgt_r_q     <= '0;
      duty_l_q    <= '0;
      duty_r_q    <= '0;
      pwm_l_q     <= 1'b0;
      pwm_r_q     <= 1'b0;
      fwd_l_q     <= 1'b1;
      fwd_r_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      turn_left_q <= turn_left_d;
      line_cmd_q  <= line_cmd_d;
      man_grant_q <= man_grant_d;
      cnt_q       <= cnt_d;
      tgt_l_q     <= tgt_l_d;
      tgt_r_q     <= tgt_r_d;
      duty_l_q    <= duty_l_d;
      duty_r_q    <= duty_r_d;
      pwm_l_q     <= pwm_l_d;
      pwm_r_q     <= pwm_r_d;
      fwd_l_q     <= fwd_l_d;
      fwd_r_q     <= fwd_r_d;
      busy_q      <= busy_d;
    end
  end

  assign man_grant = man_grant_q;
  assign pwm_l     = pwm_l_q;
  assign pwm_r     = pwm_r_q;
  assign fwd_l     = fwd_l_q;
  assign fwd_r     = fwd_r_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_motor_command_arbiter.sv
// -----------------------------------------------------------------------------
// tb_motor_command_arbiter
//
// Drives directed scenarios followed by random line/manual traffic, and checks
// every output each cycle against a timeline-based reference model.
// -----------------------------------------------------------------------------
module tb_motor_command_arbiter;

  localparam int unsigned P    = 10;
  localparam int unsigned FULL = 10;
  localparam int unsigned VEER = 6;
  localparam int unsigned HARD = 3;
  localparam int unsigned T    = 50;
  localparam int unsigned D    = 4;
  localparam int unsigned WD   = 100;

  logic       clk;
  logic       rst_n;
  logic [3:0] line_dir;
  logic       line_valid;
  logic       man_req;
  logic [3:0] man_dir;
  logic       man_grant;
  logic       pwm_l;
  logic       pwm_r;
  logic       fwd_l;
  logic       fwd_r;
  logic       busy;

  int unsigned n_checks;
  int unsigned n_fail;

  motor_command_arbiter #(
    .PWM_PERIOD      (P),
    .DUTY_FULL       (FULL),
    .DUTY_VEER       (VEER),
    .DUTY_HARD       (HARD),
    .TURN_CYCLES     (T),
    .DEAD_CYCLES     (D),
    .WATCHDOG_CYCLES (WD)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_dir   (line_dir),
    .line_valid (line_valid),
    .man_req    (man_req),
    .man_dir    (man_dir),
    .man_grant  (man_grant),
    .pwm_l      (pwm_l),
    .pwm_r      (pwm_r),
    .fwd_l      (fwd_l),
    .fwd_r      (fwd_r),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: the turn is a fixed timeline measured from its start edge;
  // PWM position is the edge count modulo the period.
  // ---------------------------------------------------------------------------
  int unsigned m_edge;
  int unsigned m_start;
  bit          m_turning;
  bit          m_left;
  bit          m_grant;
  logic [3:0]  m_line;
  int unsigned m_tgt_l, m_tgt_r;
  int unsigned m_app_l, m_app_r;
  int unsigned m_wd;
  bit          m_pwm_l, m_pwm_r, m_fwd_l, m_fwd_r;

  task automatic model_reset();
    m_edge    = 0;
    m_start   = 0;
    m_turning = 0;
    m_left    = 0;
    m_grant   = 0;
    m_line    = 4'b1111;
    m_tgt_l   = 0;
    m_tgt_r   = 0;
    m_app_l   = 0;
    m_app_r   = 0;
    m_wd      = 0;
    m_pwm_l   = 0;
    m_pwm_r   = 0;
    m_fwd_l   = 1;
    m_fwd_r   = 1;
  endtask

  function automatic bit is_turn(input logic [3:0] c);
    return (c == 4'b0111) || (c == 4'b1011);
  endfunction

  task automatic duty_of(input logic [3:0] c, output int unsigned l, output int unsigned r);
    int unsigned inner;
    logic [1:0]  dir;
    logic [1:0]  ins;
    dir = c[3:2];
    ins = c[1:0];
    if (ins == 2'b11)      inner = FULL;
    else if (ins == 2'b10) inner = HARD;
    else                   inner = VEER;
    l = FULL;
    r = FULL;
    if (dir == 2'b11) begin
      l = 0;
      r = 0;
    end else if (dir == 2'b01) begin
      l = inner;
    end else if (dir == 2'b10) begin
      r = inner;
    end
  endtask

  task automatic model_step();
    logic [3:0]  line_eff;
    logic [3:0]  sel;
    int unsigned e, o, cnt, old_l, old_r;
    bit          free, pivot, in_turn;
    line_eff = line_valid ? line_dir : m_line;
`ifdef MOTOR_WATCHDOG_EN
    if (!line_valid && (m_wd == WD) && !m_grant) line_eff = 4'b1111;
`endif
    sel  = man_req ? man_dir : line_eff;
    e    = m_edge + 1;
    free = !m_turning;
    if (free && is_turn(sel)) begin
      m_turning = 1;
      m_start   = e;
      m_left    = (sel[3:2] == 2'b01);
    end
    old_l = m_tgt_l;
    old_r = m_tgt_r;
    duty_of(sel, m_tgt_l, m_tgt_r);
    cnt   = e % P;
    pivot = 0;
    if (m_turning && ((e - m_start) >= 2 * D + T)) m_turning = 0;
    if (m_turning) begin
      o       = e - m_start;
      in_turn = (o >= D) && (o < D + T);
      m_app_l = in_turn ? FULL : 0;
      m_app_r = in_turn ? FULL : 0;
      pivot   = (o + 1 >= D) && (o < D + T);
    end else if (cnt == 0) begin
      m_app_l = old_l;
      m_app_r = old_r;
    end
    m_fwd_l = !(pivot && m_left);
    m_fwd_r = !(pivot && !m_left);
    m_pwm_l = (cnt < m_app_l);
    m_pwm_r = (cnt < m_app_r);
    if (free) m_grant = man_req;
    m_line = line_eff;
    if (line_valid)    m_wd = 0;
    else if (m_wd < WD) m_wd = m_wd + 1;
    m_edge = e;
  endtask

  always @(posedge clk) begin
    if (rst_n) model_step();
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("pwm_l", {31'd0, pwm_l}, {31'd0, m_pwm_l});
    check_eq("pwm_r", {31'd0, pwm_r}, {31'd0, m_pwm_r});
    check_eq("fwd_l", {31'd0, fwd_l}, {31'd0, m_fwd_l});
    check_eq("fwd_r", {31'd0, fwd_r}, {31'd0, m_fwd_r});
    check_eq("busy", {31'd0, busy}, {31'd0, m_turning});
    check_eq("man_grant", {31'd0, man_grant}, {31'd0, m_grant});
  endtask

  logic       cur_mr;
  logic [3:0] cur_md;
  logic [3:0] cur_ld;

  // One clock: inputs applied now, outputs checked on the following negedge.
  task automatic step(input logic lv, input logic [3:0] ld);
    line_valid = lv;
    line_dir   = ld;
    man_req    = cur_mr;
    man_dir    = cur_md;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic hold(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, cur_ld);
  endtask

  task automatic strobe(input logic [3:0] ld);
    cur_ld = ld;
    step(1'b1, ld);
  endtask

  task automatic count_high(input int unsigned n, output int unsigned hl, output int unsigned hr);
    hl = 0;
    hr = 0;
    for (int unsigned i = 0; i < n; i++) begin
      step(1'b0, cur_ld);
      hl += pwm_l;
      hr += pwm_r;
    end
  endtask

  int unsigned hl, hr;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    cur_mr     = 1'b0;
    cur_md     = 4'b0000;
    cur_ld     = 4'b1111;
    line_valid = 1'b0;
    line_dir   = 4'b1111;
    man_req    = 1'b0;
    man_dir    = 4'b0000;
    rst_n      = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Proceed: both wheels full once the first period boundary passes.
    strobe(4'b0000);
    hold(15);
    count_high(P, hl, hr);
    check_eq("t1_full_l", hl, P);
    check_eq("t1_full_r", hr, P);

    // Left veer, then left hard.
    strobe(4'b0101);
    hold(15);
    count_high(P, hl, hr);
    check_eq("t2_veer_l", hl, VEER);
    check_eq("t2_veer_r", hr, P);
    strobe(4'b0110);
    hold(15);
    count_high(P, hl, hr);
    check_eq("t2_hard_l", hl, HARD);
    check_eq("t2_hard_r", hr, P);

    // Right 90 with a stop mid-turn that must not cut it short.
    strobe(4'b1011);
    check_eq("t3_busy_rise", {31'd0, busy}, 32'd1);
    hold(D + 20);
    strobe(4'b1111);
    check_eq("t3_turn_fwd_r", {31'd0, fwd_r}, 32'd0);
    hold(T + D + 10);

    // Manual stop overrides line proceed, then releases.
    strobe(4'b0000);
    hold(20);
    cur_mr = 1'b1;
    cur_md = 4'b1111;
    step(1'b0, cur_ld);
    check_eq("t4_grant_rise", {31'd0, man_grant}, 32'd1);
    hold(25);
    check_eq("t4_pwm_low", {31'd0, pwm_l}, 32'd0);
    cur_mr = 1'b0;
    step(1'b0, cur_ld);
    check_eq("t4_grant_fall", {31'd0, man_grant}, 32'd0);
    hold(25);

    // Manual request during a turn waits for the turn to finish.
    strobe(4'b0111);
    hold(10);
    cur_mr = 1'b1;
    cur_md = 4'b0000;
    hold(5);
    check_eq("t5_grant_held", {31'd0, man_grant}, 32'd0);
    hold(2 * D + T);
    cur_mr = 1'b0;
    strobe(4'b0000);
    hold(20);

`ifdef MOTOR_WATCHDOG_EN
    strobe(4'b0000);
    hold(WD + 2 * P + 5);
    check_eq("t6_wd_pwm", {31'd0, pwm_l}, 32'd0);
`endif

    // Random traffic.
    for (int unsigned i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) cur_mr = ~cur_mr;
      if ($urandom_range(0, 15) == 0) cur_md = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) strobe(4'($urandom_range(0, 15)));
      else step(1'b0, 4'($urandom_range(0, 15)));
    end

    // Asynchronous reset in the middle of a turn.
    cur_mr = 1'b0;
    hold(2 * D + T + 2);
    strobe(4'b0111);
    hold(D + 10);
    check_eq("t6_pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_pwm_l", {31'd0, pwm_l}, 32'd0);
    check_eq("t6_rst_pwm_r", {31'd0, pwm_r}, 32'd0);
    check_eq("t6_rst_fwd_l", {31'd0, fwd_l}, 32'd1);
    check_eq("t6_rst_fwd_r", {31'd0, fwd_r}, 32'd1);
    check_eq("t6_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("t6_rst_grant", {31'd0, man_grant}, 32'd0);
    model_reset();
    cur_ld = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0) cur_mr = ~cur_mr;
      if ($urandom_range(0, 15) == 0) cur_md = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) strobe(4'($urandom_range(0, 15)));
      else step(1'b0, 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_command_arbiter.md
Name: motor_command_arbiter

Overview:
- Sits between the line-sensor direction decoder and the two H-bridge motor drivers.
- Arbitrates between the autonomous line-follow command and a manual/remote override command.
- Sequences timed 90-degree pivot turns, with dead-time around wheel reversal.
- Generates per-wheel PWM and direction signals.

Parameters:
PWM_PERIOD, 1000, PWM counter period in clk cycles
DUTY_FULL, 1000, duty count for full speed
DUTY_VEER, 600, inner-wheel duty for veer
DUTY_HARD, 300, inner-wheel duty for hard turn
TURN_CYCLES, 25_000_000, pivot duration of a 90-degree turn
DEAD_CYCLES, 50_000, both-wheels-off interval around reversal
WATCHDOG_CYCLES, 12_500_000, line-command timeout (optional feature only)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
line_dir  in  4  line-follow command: [3:2] 00 proceed, 01 left, 10 right, 11 stop; [1:0] 00 full, 01 veer, 10 hard, 11 90-degree
line_valid  in  1  line_dir qualifier, one-cycle strobe or level
man_req  in  1  manual override request, level
man_dir  in  4  manual command, same encoding as line_dir
man_grant  out  1  manual source currently owns the motors
pwm_l  out  1  left motor PWM
pwm_r  out  1  right motor PWM
fwd_l  out  1  left wheel direction, 1 = forward
fwd_r  out  1  right wheel direction, 1 = forward
busy  out  1  high in DEAD or TURN states

Behaviour:
Reset:
- Asynchronous on rst_n low: state IDLE, all counters 0, duties 0.
- pwm_l = pwm_r = 0, fwd_l = fwd_r = 1, man_grant = 0, busy = 0.
- Reset mid-turn aborts immediately with the same values.

Arbitration:
- Evaluated every cycle in IDLE and DRIVE only.
- Manual wins while man_req = 1. man_grant is a registered output: it rises 1 cycle after man_req is sampled high and falls 1 cycle after man_req is sampled low.
- Otherwise the last line_dir latched with line_valid = 1 is the selected command.
- No preemption in DEAD/TURN states. man_req arriving there is granted on return to DRIVE/IDLE.
- If line and manual both present a 90-degree command in the same cycle, manual wins.

Command decode (selected command -> target duty / direction):
- Proceed, any intensity: L = R = DUTY_FULL, both forward.
- Left, full or veer: L = DUTY_VEER, R = DUTY_FULL. Left hard: L = DUTY_HARD, R = DUTY_FULL. Right is the mirror image.
- Left 90 (0111): pivot with fwd_l = 0, fwd_r = 1, both at DUTY_FULL. Right 90 (1011) is the mirror image.
- Stop (11xx): both duties 0.

State machine (states IDLE, DRIVE, DEAD_IN, TURN, DEAD_OUT):
- IDLE -> DRIVE when the selected command is not stop. DRIVE -> IDLE on stop.
- IDLE/DRIVE -> DEAD_IN on a 90-degree command. The turn direction is latched at this point.
- DEAD_IN: duties 0 for DEAD_CYCLES. fwd bits switch on the last DEAD_IN cycle. Then -> TURN.
- TURN: pivot duties for TURN_CYCLES. Then -> DEAD_OUT.
- DEAD_OUT: duties 0 for DEAD_CYCLES, fwd restored to 1. Then -> DRIVE (command re-evaluated there, so a still-present 90 command starts a new turn).
- Stop commands received during DEAD_IN/TURN/DEAD_OUT are ignored. The turn always completes.

PWM:
- Free-running counter 0..PWM_PERIOD-1.
- pwm_x = (cnt < duty_x), registered.
- Target duty is updated 1 cycle after a command change. Applied duty loads only when cnt = PWM_PERIOD-1, so no glitched periods.
- Exception: entering DEAD_IN/DEAD_OUT, or reset, forces applied duty 0 immediately, and pwm goes low the next cycle.
- Duty 0 means constantly low. Duty >= PWM_PERIOD means constantly high.

Optional Feature:
MOTOR_WATCHDOG_EN:
- Defined: a counter clears on every line_valid = 1 and otherwise counts up. At WATCHDOG_CYCLES with man_grant = 0, the line command is forced to stop (1111) until the next line_valid. A TURN in progress is unaffected.
- Not defined: the counter is absent and the last valid line command persists indefinitely.

Test Plan:
Bench parameters: PWM_PERIOD=10, DUTY_FULL=10, DUTY_VEER=6, DUTY_HARD=3, TURN_CYCLES=50, DEAD_CYCLES=4, WATCHDOG_CYCLES=100.
1. Reset, then line_dir=0000 with line_valid -> within the next PWM period pwm_l = pwm_r = 1 continuously, fwd = 11, busy = 0.
2. line_dir=0101 -> from the next period boundary, pwm_l high 6 of 10 cycles and pwm_r high 10 of 10. Then 0110 -> pwm_l 3 of 10.
3. line_dir=1011 -> busy rises the next cycle; 4 cycles both pwm low; 50 cycles pwm high with fwd_l=1, fwd_r=0; 4 cycles low; returns to DRIVE. A stop issued mid-TURN has no effect.
4. Line proceeding, man_req=1 with man_dir=1111 -> man_grant=1 one cycle later, pwm low from the next boundary. Drop man_req -> grant falls and line proceed resumes.
5. man_req asserted during TURN -> man_grant stays 0 until DEAD_OUT ends, then rises 1 cycle after return to DRIVE.
6. With MOTOR_WATCHDOG_EN: line 0000 then no line_valid for 100 cycles -> pwm low. Assert rst_n=0 mid-TURN -> all outputs at reset values in the same cycle.
